// File: rtl/cpu_pkg.sv
// Shared definitions for the VeriRISC control path: opcodes, phase names,
// run-state encoding and the ALU-opcode classifier.
package cpu_pkg;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } run_state_t;

  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational strobe decode from (phase, opcode, zero). When not active
// (HALTED) every strobe is low and halt is high.
module cpu_ctrl_decode
  import cpu_pkg::*;
#(
  parameter int OPW = 3,
  parameter int PHW = 3
) (
  input  logic [PHW-1:0] phase,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           active,
  output logic           sel,
  output logic           rd,
  output logic           ld_ir,
  output logic           inc_pc,
  output logic           ld_pc,
  output logic           ld_ac,
  output logic           wr,
  output logic           data_e,
  output logic           halt
);

  logic alu;
  assign alu = is_aluop(opcode);

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = !active;
    if (active) begin
      case (phase)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        INST_LOAD,
        IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        OP_ADDR:    begin inc_pc = 1'b1; halt = (opcode == HLT); end
        OP_FETCH:   rd = alu;
        ALU_OP: begin
          rd     = alu;
          inc_pc = (opcode == SKZ) && zero;
          ld_pc  = (opcode == JMP);
          data_e = (opcode == STO);
        end
        STORE: begin
          rd     = alu;
          ld_ac  = alu;
          ld_pc  = (opcode == JMP);
          wr     = (opcode == STO);
          data_e = (opcode == STO);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_control.sv
// VeriRISC sequencer: run/halt FSM plus 8-phase counter driving the strobe decode.
// Define CPU_CTRL_STEP_EN to enable single-step (STEP state, step input).
module cpu_control
  import cpu_pkg::*;
#(
  parameter int OPW = 3,
  parameter int PHW = 3
) (
  input  logic           clock,
  input  logic           rst_,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           resume,
  input  logic           step,
  output logic           sel,
  output logic           rd,
  output logic           ld_ir,
  output logic           inc_pc,
  output logic           ld_pc,
  output logic           ld_ac,
  output logic           wr,
  output logic           data_e,
  output logic           halt,
  output logic [PHW-1:0] phase
);

  run_state_t     state, state_nxt;
  logic [PHW-1:0] phase_nxt;
  logic           hlt_hit;

  // HLT stops the sequence after its phase-4 strobes (PC already incremented).
  assign hlt_hit = (phase == OP_ADDR) && (opcode == HLT);

`ifndef CPU_CTRL_STEP_EN
  logic unused_step;
  assign unused_step = step;
`endif

  always_ff @(posedge clock) begin
    if (!rst_) begin
      state <= RUN;
      phase <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      RUN: begin
        if (hlt_hit) begin
          state_nxt = HALTED;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
`ifdef CPU_CTRL_STEP_EN
      STEP: begin
        if (hlt_hit || (phase == STORE)) begin
          state_nxt = HALTED;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
`endif
      HALTED: begin
        phase_nxt = '0;
        if (resume) begin
          state_nxt = RUN;
`ifdef CPU_CTRL_STEP_EN
        end else if (step) begin
          state_nxt = STEP;
`endif
        end
      end
      default: begin
        state_nxt = RUN;
        phase_nxt = '0;
      end
    endcase
  end

  cpu_ctrl_decode #(.OPW(OPW), .PHW(PHW)) u_decode (
    .phase  (phase),
    .opcode (opcode),
    .zero   (zero),
    .active (state != HALTED),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt)
  );

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: expected strobe vectors are pushed to a
// queue from a reference table and popped/compared once per cycle on the falling edge.
module tb_cpu_control;
  import cpu_pkg::*;

  logic       clock = 1'b0;
  logic       rst_;
  logic [2:0] opcode;
  logic       zero, resume, step;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] exp_q[$];
  logic [11:0] got;
  logic [11:0] e;

  assign got = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase};

  cpu_control #(.OPW(3), .PHW(3)) dut (
    .clock(clock), .rst_(rst_), .opcode(opcode), .zero(zero),
    .resume(resume), .step(step), .sel(sel), .rd(rd), .ld_ir(ld_ir),
    .inc_pc(inc_pc), .ld_pc(ld_pc), .ld_ac(ld_ac), .wr(wr),
    .data_e(data_e), .halt(halt), .phase(phase)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // reference table: {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt,phase}
  function automatic logic [11:0] exp_vec(input bit halted, input logic [2:0] op,
                                          input logic z, input logic [2:0] ph);
    logic s, r, li, ip, lp, la, w, de, h, alu;
    {s, r, li, ip, lp, la, w, de, h} = 9'b0;
    alu = (op >= 3'd2) && (op <= 3'd5);
    if (halted) return {8'b0, 1'b1, 3'd0};
    case (ph)
      3'd0: s = 1'b1;
      3'd1: begin s = 1'b1; r = 1'b1; end
      3'd2, 3'd3: begin s = 1'b1; r = 1'b1; li = 1'b1; end
      3'd4: begin ip = 1'b1; h = (op == 3'd0); end
      3'd5: r = alu;
      3'd6: begin r = alu; ip = (op == 3'd1) && z; lp = (op == 3'd7); de = (op == 3'd6); end
      default: begin r = alu; la = alu; lp = (op == 3'd7); w = (op == 3'd6); de = (op == 3'd6); end
    endcase
    return {s, r, li, ip, lp, la, w, de, h, ph};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push_instr(input logic [2:0] op, input logic z, input int nph);
    for (int p = 0; p < nph; p++) exp_q.push_back(exp_vec(1'b0, op, z, 3'(p)));
  endtask

  task automatic push_halted(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_vec(1'b1, 3'd0, 1'b0, 3'd0));
  endtask

  task automatic test_reset();
    opcode = LDA; zero = 1'b0; resume = 1'b0; step = 1'b0; rst_ = 1'b0;
    tick();
    exp_q.push_back(exp_vec(1'b0, LDA, 1'b0, 3'd0));
    e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL reset: got %b expected %b", got, e); end
    rst_ = 1'b1;
  endtask

  task automatic test_lda();
    opcode = LDA; zero = 1'b0;
    push_instr(LDA, 1'b0, 8);
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL lda ph%0d: got %b expected %b", i, got, e); end
      tick();
    end
  endtask

  task automatic test_sto_skz_jmp();
    logic [2:0] ops[4] = '{STO, SKZ, SKZ, JMP};
    logic       zs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      opcode = ops[k]; zero = zs[k];
      push_instr(ops[k], zs[k], 8);
      for (int i = 0; i < 8; i++) begin
        e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin
          n_fail++; $display("FAIL op%0d z%0d ph%0d: got %b expected %b", ops[k], zs[k], i, got, e);
        end
        tick();
      end
    end
  endtask

  task automatic test_halt_resume();
    opcode = HLT; zero = 1'b0;
    push_instr(HLT, 1'b0, 5);
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL hlt ph%0d: got %b expected %b", i, got, e); end
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      opcode = 3'($urandom_range(0, 7)); zero = 1'($urandom_range(0, 1));
      push_halted(1);
      e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL halted c%0d: got %b expected %b", i, got, e); end
      tick();
    end
    opcode = ADD; zero = 1'b0; resume = 1'b1;
    tick();
    resume = 1'b0;
    push_instr(ADD, 1'b0, 8);
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL resume ph%0d: got %b expected %b", i, got, e); end
      tick();
    end
  endtask

  task automatic test_step();
    int ld_ac_cnt;
    opcode = HLT;
    push_instr(HLT, 1'b0, 5);
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL step_hlt ph%0d: got %b expected %b", i, got, e); end
      tick();
    end
    opcode = ADD; step = 1'b1;
    tick();
    step = 1'b0;
`ifdef CPU_CTRL_STEP_EN
    ld_ac_cnt = 0;
    push_instr(ADD, 1'b0, 8);
    push_halted(3);
    for (int i = 0; i < 11; i++) begin
      ld_ac_cnt += int'(ld_ac);
      e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL step_add c%0d: got %b expected %b", i, got, e); end
      tick();
    end
    n_tests++;
    if (ld_ac_cnt !== 1) begin n_fail++; $display("FAIL step_ld_ac_count: got %0d expected 1", ld_ac_cnt); end
    // HLT fetched while stepping stops at phase 4
    step = 1'b1;
    tick();
    step = 1'b0; opcode = HLT;
    push_instr(HLT, 1'b0, 5);
    push_halted(2);
    for (int i = 0; i < 7; i++) begin
      e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL step_hlt2 c%0d: got %b expected %b", i, got, e); end
      tick();
    end
`else
    ld_ac_cnt = 0;
    push_halted(3);
    for (int i = 0; i < 3; i++) begin
      ld_ac_cnt += int'(ld_ac);
      e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL step_ignored c%0d: got %b expected %b", i, got, e); end
      tick();
    end
    n_tests++;
    if (ld_ac_cnt !== 0) begin n_fail++; $display("FAIL step_ld_ac_count: got %0d expected 0", ld_ac_cnt); end
`endif
    // resume and step together: resume wins, execution continues past phase 7
    opcode = ADD; step = 1'b1; resume = 1'b1;
    tick();
    step = 1'b0; resume = 1'b0;
    push_instr(ADD, 1'b0, 8);
    push_instr(ADD, 1'b0, 8);
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL step_resume c%0d: got %b expected %b", i, got, e); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    logic       z;
    for (int k = 0; k < 6; k++) begin
      op = 3'($urandom_range(1, 7)); z = 1'($urandom_range(0, 1));
      opcode = op; zero = z;
      push_instr(op, z, 8);
      for (int i = 0; i < 8; i++) begin
        resume = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
        e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL b2b op%0d ph%0d: got %b expected %b", op, i, got, e); end
        tick();
      end
    end
    resume = 1'b0; step = 1'b0;
  endtask

  task automatic test_reset_mid_store();
    logic wr_seen;
    wr_seen = 1'b0;
    opcode = STO; zero = 1'b0;
    push_instr(STO, 1'b0, 7);
    for (int i = 0; i < 7; i++) begin
      wr_seen |= wr;
      e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL rst_sto ph%0d: got %b expected %b", i, got, e); end
      if (i == 6) rst_ = 1'b0;
      tick();
    end
    wr_seen |= wr;
    rst_ = 1'b1;
    exp_q.push_back(exp_vec(1'b0, STO, 1'b0, 3'd0));
    e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL rst_sto_after: got %b expected %b", got, e); end
    n_tests++;
    if (wr_seen !== 1'b0) begin n_fail++; $display("FAIL rst_sto_wr: got %b expected 0", wr_seen); end
  endtask

  initial begin
    rst_ = 1'b0; opcode = LDA; zero = 1'b0; resume = 1'b0; step = 1'b0;
    @(negedge clock);
    test_reset();
    test_lda();
    test_sto_skz_jmp();
    test_halt_resume();
    test_step();
    test_back_to_back();
    test_reset_mid_store();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
